// File: rtl/pll_rst_ctrl_pkg.sv
// Shared types and constants for the PLL-driven reset sequencer.
package pll_rst_ctrl_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK   = 2'd0,
        STABLE      = 2'd1,
        PERIPH_ONLY = 2'd2,
        RUN         = 2'd3
    } rst_state_e;

    localparam int LOSS_CNT_W = 8;

endpackage : pll_rst_ctrl_pkg

// File: rtl/bit_sync.sv
// Single-bit clock-domain-crossing synchronizer: a chain of STAGES flops
// with a synchronous active-high clear.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] chain_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            chain_q <= '0;
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = chain_q[STAGES-1];

endmodule : bit_sync

// File: rtl/pll_rst_ctrl.sv
// Reset sequencer behind the fabric PLL: waits for a stable lock, releases the
// peripheral reset, then the core reset, and re-asserts both on lock loss or
// a software request.
module pll_rst_ctrl
    import pll_rst_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES           = 2,
    parameter int LOCK_STABLE_CYCLES    = 1024,
    parameter int PERIPH_TO_CORE_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pll_lock_i,
    input  logic                  sw_rst_req_i,
    output logic                  periph_rst_o,
    output logic                  core_rst_o,
    output logic                  ready_o,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o
);

    localparam int MAX_CYCLES = (LOCK_STABLE_CYCLES > PERIPH_TO_CORE_CYCLES) ?
                                LOCK_STABLE_CYCLES : PERIPH_TO_CORE_CYCLES;
    localparam int CNT_W = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CORE_LAST   = CNT_W'(PERIPH_TO_CORE_CYCLES - 1);

    logic                  lock_s;
    rst_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [LOSS_CNT_W-1:0] loss_q, loss_d;
    logic                  periph_rst_q, periph_rst_d;
    logic                  core_rst_q, core_rst_d;
    logic                  ready_q, ready_d;
    logic                  loss_event;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (pll_lock_i),
        .q_o   (lock_s)
    );

    // One counter is shared: it times the lock-stable window in STABLE and
    // the peripheral-to-core gap in PERIPH_ONLY.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        loss_event = 1'b0;

        case (state_q)
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            STABLE: begin
                if (!lock_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (sw_rst_req_i) begin
                    cnt_d = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = PERIPH_ONLY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PERIPH_ONLY: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    cnt_d      = '0;
                    loss_event = 1'b1;
                end else if (sw_rst_req_i) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CORE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_d    = WAIT_LOCK;
                    cnt_d      = '0;
                    loss_event = 1'b1;
                end else if (sw_rst_req_i) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
                cnt_d   = '0;
            end
        endcase

        loss_d = loss_q;
        if (loss_event && (loss_q != {LOSS_CNT_W{1'b1}})) begin
            loss_d = loss_q + 1'b1;
        end

        // Outputs follow the next state so they move on the same edge.
        periph_rst_d = (state_d == WAIT_LOCK) || (state_d == STABLE);
        core_rst_d   = (state_d != RUN);
        ready_d      = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            loss_q       <= '0;
            periph_rst_q <= 1'b1;
            core_rst_q   <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            loss_q       <= loss_d;
            periph_rst_q <= periph_rst_d;
            core_rst_q   <= core_rst_d;
            ready_q      <= ready_d;
        end
    end

    assign periph_rst_o    = periph_rst_q;
    assign core_rst_o      = core_rst_q;
    assign ready_o         = ready_q;
    assign lock_loss_cnt_o = loss_q;

endmodule : pll_rst_ctrl
